// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART command sequencer.
// Holds the sequencer state encoding and the two protocol opcodes.
// Pure declarations; no logic, no timing.
package uart_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    WR_STB,
    RD_ADDR,
    RD_STB,
    RD_WAIT,
    TX_WAIT
  } state_t;

  localparam logic [7:0] CMD_WR = 8'hAA;
  localparam logic [7:0] CMD_RD = 8'hBB;

  // An address byte is usable only if nothing is set at or above bit addr_w.
  function automatic logic addr_fits(input logic [7:0] b, input int addr_w);
    return (b >> addr_w) == 8'd0;
  endfunction

endpackage

// File: rtl/uart_cmd_ctrl_timer.sv
// Inter-byte timeout counter for the command sequencer.
// Latency: expired is combinational from the count; count updates each cycle.
// Backpressure: none; counts while run=1, restarts on clr, holds at the limit.
// Ports: clk, rst (async, active high), clr (restart), run (count enable),
//        expired (count has reached TIMEOUT_CYCLES-1 while running).
module cmd_timer #(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (run && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = run && (cnt == LAST);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Command sequencer: parses 0xAA addr data (write) / 0xBB addr (read) from RX, strobes the regfile, returns read bytes to TX.
// Latency: reg_wr_en 2 cycles after data byte, reg_rd_en 2 cycles after address byte, tx_valid 1 cycle after rd return/tx_busy low.
// Backpressure: tx_busy holds the read response in TX_WAIT; bytes arriving while a command executes are dropped with cmd_err.
// Ports: clk, rst (async, active high); rx_data/rx_valid/rx_err from the UART receiver;
//        reg_addr/reg_wr_en/reg_wr_data/reg_rd_en out and reg_rd_data/reg_rd_valid in to the register file;
//        tx_data/tx_valid out and tx_busy in to the transmitter; cmd_err error pulse; busy = not IDLE.
// Optional build macro CMD_TIMEOUT_EN: adds an inter-byte timeout of TIMEOUT_CYCLES in the byte-wait states.
// All outputs come straight from flops.
module uart_cmd_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int ADDR_W         = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              rx_err,
  output logic [ADDR_W-1:0] reg_addr,
  output logic              reg_wr_en,
  output logic [7:0]        reg_wr_data,
  output logic              reg_rd_en,
  input  logic [7:0]        reg_rd_data,
  input  logic              reg_rd_valid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_busy,
  output logic              cmd_err,
  output logic              busy
);

  state_t            state, state_d;
  logic [ADDR_W-1:0] addr_d;
  logic [7:0]        data_d, resp_d;
  logic              wr_en_d, rd_en_d, tx_valid_d, err_d;
  logic              byte_ok, byte_bad;
  logic              tmo_expired;

  assign byte_ok  = rx_valid && !rx_err;
  assign byte_bad = rx_valid && rx_err;

`ifdef CMD_TIMEOUT_EN
  logic tmr_run, tmr_clr;

  assign tmr_run = state inside {WR_ADDR, WR_DATA, RD_ADDR};
  // Restart on every received byte and whenever the state changes.
  assign tmr_clr = rx_valid || (state_d != state);

  cmd_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .run     (tmr_run),
    .expired (tmo_expired)
  );
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign tmo_expired = 1'b0;
`endif

  always_comb begin
    state_d    = state;
    addr_d     = reg_addr;
    data_d     = reg_wr_data;
    resp_d     = tx_data;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    tx_valid_d = 1'b0;
    err_d      = 1'b0;

    case (state)
      IDLE: begin
        if (byte_bad) begin
          err_d = 1'b1;
        end else if (byte_ok) begin
          if (rx_data == CMD_WR)      state_d = WR_ADDR;
          else if (rx_data == CMD_RD) state_d = RD_ADDR;
          else                        err_d   = 1'b1;
        end
      end

      WR_ADDR, RD_ADDR: begin
        if (byte_bad) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (byte_ok) begin
          if (addr_fits(rx_data, ADDR_W)) begin
            addr_d  = rx_data[ADDR_W-1:0];
            state_d = (state == WR_ADDR) ? WR_DATA : RD_STB;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end else if (tmo_expired) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end

      WR_DATA: begin
        if (byte_bad) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (byte_ok) begin
          data_d  = rx_data;
          state_d = WR_STB;
        end else if (tmo_expired) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end

      WR_STB: begin
        // A corrupted byte here aborts the write; a clean one is only dropped.
        state_d = IDLE;
        err_d   = rx_valid;
        wr_en_d = !byte_bad;
      end

      RD_STB: begin
        rd_en_d = 1'b1;
        err_d   = rx_valid;
        state_d = RD_WAIT;
      end

      RD_WAIT: begin
        err_d = rx_valid;
        if (reg_rd_valid) begin
          resp_d = reg_rd_data;
          // Transmitter already free: send now rather than spend a cycle in TX_WAIT.
          tx_valid_d = !tx_busy;
          state_d    = TX_WAIT;
        end
      end

      TX_WAIT: begin
        err_d = rx_valid;
        // tx_valid is registered, so a high tx_valid here means the byte has gone.
        if (tx_valid)      state_d    = IDLE;
        else if (!tx_busy) tx_valid_d = 1'b1;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      reg_addr    <= '0;
      reg_wr_data <= '0;
      tx_data     <= '0;
      reg_wr_en   <= 1'b0;
      reg_rd_en   <= 1'b0;
      tx_valid    <= 1'b0;
      cmd_err     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_d;
      reg_addr    <= addr_d;
      reg_wr_data <= data_d;
      tx_data     <= resp_d;
      reg_wr_en   <= wr_en_d;
      reg_rd_en   <= rd_en_d;
      tx_valid    <= tx_valid_d;
      cmd_err     <= err_d;
      busy        <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: directed scenarios then random command mix.
// Expected events are derived per command from protocol rules (byte stamps + fixed latencies).
// Register file and transmitter are modelled by the bench; tx_busy windows are bench-chosen.
module tb_uart_cmd_ctrl;

  localparam int ADDR_W = 4;
  localparam int TMO    = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_err;
  logic [ADDR_W-1:0] reg_addr;
  logic              reg_wr_en;
  logic [7:0]        reg_wr_data;
  logic              reg_rd_en;
  logic [7:0]        reg_rd_data;
  logic              reg_rd_valid;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_busy;
  logic              cmd_err;
  logic              busy;

  uart_cmd_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_err       (rx_err),
    .reg_addr     (reg_addr),
    .reg_wr_en    (reg_wr_en),
    .reg_wr_data  (reg_wr_data),
    .reg_rd_en    (reg_rd_en),
    .reg_rd_data  (reg_rd_data),
    .reg_rd_valid (reg_rd_valid),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_busy      (tx_busy),
    .cmd_err      (cmd_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // cyc = number of rising edges so far; a "stamp" names the edge that ends a cycle.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Register file contents (environment) and the reference image of it.
  logic [7:0] rf      [16];
  logic [7:0] ref_mem [16];

  // Observed events, stamped.
  int         wr_stamp_q[$];
  logic [7:0] wr_addr_q[$];
  logic [7:0] wr_data_q[$];
  int         rd_stamp_q[$];
  int         tx_stamp_q[$];
  logic [7:0] tx_data_q[$];
  int         err_stamp_q[$];
  int         excl_viol = 0;

  always @(negedge clk) begin
    if (reg_wr_en === 1'b1) begin
      wr_stamp_q.push_back(cyc + 1);
      wr_addr_q.push_back(8'(reg_addr));
      wr_data_q.push_back(reg_wr_data);
      rf[reg_addr] = reg_wr_data;
    end
    if (reg_rd_en === 1'b1) rd_stamp_q.push_back(cyc + 1);
    if (tx_valid === 1'b1) begin
      tx_stamp_q.push_back(cyc + 1);
      tx_data_q.push_back(tx_data);
    end
    if (cmd_err === 1'b1) err_stamp_q.push_back(cyc + 1);
    if (int'(reg_wr_en) + int'(reg_rd_en) + int'(tx_valid) > 1) excl_viol++;
  end

  // Register-file read responder with bench-chosen latency and tx_busy window.
  int rsp_delay = 0;
  int busy_len  = 0;
  int rdv_stamp = 0;
  logic rsp_active = 1'b0;

  initial begin
    logic [3:0] a;
    reg_rd_valid = 1'b0;
    reg_rd_data  = 8'h00;
    tx_busy      = 1'b0;
    forever begin
      @(negedge clk);
      if (reg_rd_en === 1'b1) begin
        a = reg_addr;
        rsp_active = 1'b1;
        repeat (rsp_delay) @(posedge clk);
        @(posedge clk); #1;
        reg_rd_valid = 1'b1;
        reg_rd_data  = rf[a];
        rdv_stamp    = cyc + 1;
        tx_busy      = (busy_len != 0);
        @(posedge clk); #1;
        reg_rd_valid = 1'b0;
        reg_rd_data  = 8'($urandom);
        for (int k = 1; k < busy_len; k++) begin
          @(posedge clk); #1;
        end
        tx_busy    = 1'b0;
        rsp_active = 1'b0;
      end
    end
  end

  // All byte tasks start and end at rising edge + 1.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      rx_valid = 1'b0;
      rx_err   = 1'($urandom_range(0, 1));
      rx_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    rx_err = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic e, output int stamp);
    rx_valid = 1'b1;
    rx_data  = b;
    rx_err   = e;
    stamp    = cyc + 1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_err   = 1'b0;
  endtask

  task automatic clear_obs();
    wr_stamp_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
    rd_stamp_q.delete(); tx_stamp_q.delete(); tx_data_q.delete();
    err_stamp_q.delete();
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while ((busy !== 1'b0 || rsp_active) && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 200) check({tag, "_done_timeout"}, 1, 0);
    idle(3);
  endtask

  // kind: 0 write(a,d) 1 read(a) 2 bad opcode d 3 bad addr byte d (a[0] picks read)
  //       4 write(a,d) with rx_err on byte index pos 5 read(a) + stray byte
  task automatic run_txn(input int kind, input logic [3:0] a, input logic [7:0] d,
                         input int blen, input int dly, input int pos);
    int s, s2, exp_err[$];
    int n_wr, n_rd, n_tx, e_wr, e_rd;
    logic [7:0] e_tx;
    logic [7:0] bytes[3];
    n_wr = 0; n_rd = 0; n_tx = 0; e_wr = 0; e_rd = 0; e_tx = 8'h00;
    busy_len = blen;
    rsp_delay = dly;
    clear_obs();
    case (kind)
      0: begin
        send_byte(8'hAA, 1'b0, s);
        check("busy_after_opcode", busy, 1);
        idle($urandom_range(0, 3));
        send_byte(8'(a), 1'b0, s);
        idle($urandom_range(0, 3));
        send_byte(d, 1'b0, s);
        n_wr = 1; e_wr = s + 2;
        ref_mem[a] = d;
      end
      1, 5: begin
        send_byte(8'hBB, 1'b0, s);
        idle($urandom_range(0, 3));
        send_byte(8'(a), 1'b0, s);
        n_rd = 1; e_rd = s + 2;
        n_tx = 1; e_tx = ref_mem[a];
        if (kind == 5) begin
          send_byte(8'($urandom), 1'($urandom_range(0, 1)), s2);
          exp_err.push_back(s2 + 1);
        end
      end
      2: begin
        send_byte(d, 1'b0, s);
        exp_err.push_back(s + 1);
      end
      3: begin
        send_byte(a[0] ? 8'hBB : 8'hAA, 1'b0, s);
        idle($urandom_range(0, 3));
        send_byte(d, 1'b0, s);
        exp_err.push_back(s + 1);
      end
      default: begin
        bytes[0] = 8'hAA; bytes[1] = 8'(a); bytes[2] = d;
        for (int i = 0; i <= pos; i++) begin
          send_byte(bytes[i], i == pos, s);
          if (i != pos) idle($urandom_range(0, 3));
        end
        exp_err.push_back(s + 1);
      end
    endcase
    wait_done("txn");
    check("idle_after_txn", busy, 0);

    check("wr_count", wr_stamp_q.size(), n_wr);
    if (n_wr == 1 && wr_stamp_q.size() == 1) begin
      check("wr_latency", wr_stamp_q[0], e_wr);
      check("wr_addr", wr_addr_q[0], 8'(a));
      check("wr_data", wr_data_q[0], d);
    end
    check("rd_count", rd_stamp_q.size(), n_rd);
    if (n_rd == 1 && rd_stamp_q.size() == 1) check("rd_latency", rd_stamp_q[0], e_rd);
    check("tx_count", tx_stamp_q.size(), n_tx);
    if (n_tx == 1 && tx_stamp_q.size() == 1) begin
      check("tx_data", tx_data_q[0], e_tx);
      check("tx_latency", tx_stamp_q[0], rdv_stamp + blen + 1);
    end
    check("err_count", err_stamp_q.size(), exp_err.size());
    for (int i = 0; i < exp_err.size() && i < err_stamp_q.size(); i++)
      check("err_latency", err_stamp_q[i], exp_err[i]);
  endtask

  task automatic timeout_test();
    int s;
    busy_len = 0; rsp_delay = 0;
    clear_obs();
    send_byte(8'hBB, 1'b0, s);
`ifdef CMD_TIMEOUT_EN
    idle(TMO + 4);
    check("tmo_err_count", err_stamp_q.size(), 1);
    if (err_stamp_q.size() == 1) check("tmo_err_time", err_stamp_q[0], s + TMO + 1);
    check("tmo_busy", busy, 0);
`else
    idle(40);
    check("notmo_busy", busy, 1);
    check("notmo_err_count", err_stamp_q.size(), 0);
    send_byte(8'h02, 1'b0, s);
    wait_done("notmo");
    check("notmo_rd_count", rd_stamp_q.size(), 1);
    check("notmo_tx_count", tx_stamp_q.size(), 1);
    if (tx_data_q.size() == 1) check("notmo_tx_data", tx_data_q[0], ref_mem[2]);
`endif
  endtask

  task automatic reset_test();
    int s;
    busy_len = 0; rsp_delay = 6;
    clear_obs();
    send_byte(8'hBB, 1'b0, s);
    idle(1);
    send_byte(8'h09, 1'b0, s);
    idle(3);
    check("busy_pre_reset", busy, 1);
    #2 rst = 1'b1;
    #1 check("outputs_on_reset",
             {reg_addr, reg_wr_en, reg_wr_data, reg_rd_en, tx_data, tx_valid, cmd_err, busy}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(20);
    wait_done("rst");
    check("rst_rd_count", rd_stamp_q.size(), 1);
    check("rst_tx_count", tx_stamp_q.size(), 0);
    check("rst_wr_count", wr_stamp_q.size(), 0);
    check("rst_err_count", err_stamp_q.size(), 0);
  endtask

  initial begin
    logic [3:0] ra;
    logic [7:0] op;
    int kind;
    rst = 1'b1;
    rx_valid = 1'b0; rx_err = 1'b0; rx_data = 8'h00;
    for (int i = 0; i < 16; i++) begin
      rf[i] = 8'($urandom);
      ref_mem[i] = rf[i];
    end
    rf[7] = 8'hA5; ref_mem[7] = 8'hA5;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          {reg_addr, reg_wr_en, reg_wr_data, reg_rd_en, tx_data, tx_valid, cmd_err, busy}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_txn(0, 4'd3, 8'h5C, 0, 0, 0);   // write 0x5C to 3
    run_txn(1, 4'd7, 8'h00, 10, 1, 0);  // read 7 with tx_busy for 10 cycles
    run_txn(2, 4'd0, 8'h12, 0, 0, 0);   // bad opcode
    run_txn(3, 4'd0, 8'h13, 0, 0, 0);   // write with out-of-range address
    run_txn(4, 4'd5, 8'h77, 0, 0, 2);   // rx_err on the data byte
    run_txn(0, 4'd5, 8'h3C, 0, 0, 0);   // follow-up write executes
    run_txn(1, 4'd5, 8'h00, 0, 0, 0);   // and reads back
    timeout_test();
    reset_test();

    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 5);
      ra   = 4'($urandom);
      case (kind)
        2: begin
          op = 8'($urandom);
          if (op == 8'hAA || op == 8'hBB) op = 8'h00;
          run_txn(2, ra, op, 0, 0, 0);
        end
        3: run_txn(3, ra, 8'(ra) | (8'h10 << $urandom_range(0, 3)), 0, 0, 0);
        4: run_txn(4, ra, 8'($urandom), 0, 0, $urandom_range(0, 2));
        default: run_txn(kind, ra, 8'($urandom), $urandom_range(0, 12), $urandom_range(0, 3), 0);
      endcase
    end

    check("strobe_exclusive", excl_viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/uart_cmd_ctrl.md
# uart_cmd_ctrl

Command sequencer between the UART receiver output (parallel byte plus valid strobe) and the system register file and UART transmitter. It parses a byte-stream protocol of write and read commands and drives register-file write and read strobes. It also schedules read-back bytes to the transmitter under a busy/valid handshake. This is the block that gives the RX/TX datapath a purpose at system level.

## Interface
- ADDR_W, default 4: register-file address width; must be at most 8.
- TIMEOUT_CYCLES, default 65535: inter-byte timeout in clk cycles; only used when the timeout feature is compiled in.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx_data  in  8  received byte; sampled only when rx_valid=1.
- rx_valid  in  1  one-cycle strobe; a new byte is on rx_data.
- rx_err  in  1  parity or stop error for the byte strobed this cycle; qualified by rx_valid.
- reg_addr  out  ADDR_W  register address; held from address capture until the next command.
- reg_wr_en  out  1  one-cycle write strobe.
- reg_wr_data  out  8  write data; valid when reg_wr_en=1.
- reg_rd_en  out  1  one-cycle read strobe.
- reg_rd_data  in  8  read data; valid when reg_rd_valid=1.
- reg_rd_valid  in  1  one-cycle read-return strobe.
- tx_data  out  8  byte for the transmitter.
- tx_valid  out  1  one-cycle transmit request.
- tx_busy  in  1  transmitter busy; no tx_valid while it is high.
- cmd_err  out  1  one-cycle pulse on any protocol error.
- busy  out  1  high in every state except IDLE.

## Operation
- Protocol:
  - Write: 0xAA, addr, data.
  - Read: 0xBB, addr; the response is one byte to TX.
- Address byte: bits [ADDR_W-1:0] form the address. If any bit at or above ADDR_W is 1, the block pulses cmd_err and returns to IDLE.
- States and transitions:
  - IDLE:
    - Byte 0xAA goes to WR_ADDR.
    - Byte 0xBB goes to RD_ADDR.
    - Any other byte pulses cmd_err and stays in IDLE.
  - WR_ADDR: a valid byte captures reg_addr and goes to WR_DATA.
  - WR_DATA: a valid byte goes to WR_STB.
  - WR_STB: reg_wr_en=1 for one cycle, with reg_wr_data equal to the captured byte; then IDLE.
  - RD_ADDR: a valid byte captures reg_addr and goes to RD_STB.
  - RD_STB: reg_rd_en=1 for one cycle; then RD_WAIT.
  - RD_WAIT: reg_rd_valid captures reg_rd_data into the response register and goes to TX_WAIT.
  - TX_WAIT: when tx_busy=0, tx_valid=1 for one cycle with tx_data equal to the response; then IDLE.
- rx_valid with rx_err=1, in any state: the byte is discarded, cmd_err pulses, and the next state is IDLE.
  - Exception: in RD_STB, RD_WAIT and TX_WAIT the erroneous byte is dropped and cmd_err pulses, but the read completes normally.
- rx_valid with a good byte in WR_STB, RD_STB, RD_WAIT or TX_WAIT: the byte is dropped, cmd_err pulses, and the state is unchanged. Commands are not pipelined.
- rx_err is ignored when rx_valid=0.
- Only one of reg_wr_en, reg_rd_en and tx_valid is ever high in a given cycle.

## Timing
- Reset values: state IDLE; all of the following are 0:
  - reg_addr, reg_wr_en, reg_wr_data, reg_rd_en;
  - tx_data, tx_valid;
  - cmd_err, busy;
  - response register and timeout counter.
- All outputs are registered.
- Write latency: reg_wr_en asserts exactly 2 cycles after the rx_valid of the data byte.
- Read strobe: reg_rd_en asserts exactly 2 cycles after the rx_valid of the address byte.
- Read return: tx_valid asserts 1 cycle after reg_rd_valid when tx_busy=0. Otherwise it asserts 1 cycle after the first cycle in which tx_busy is sampled 0.
- cmd_err asserts 1 cycle after the offending rx_valid.
- Reset asserted mid-command clears all state asynchronously; no partial strobe is emitted.

## Configuration
- CMD_TIMEOUT_EN defined:
  - A counter runs in WR_ADDR, WR_DATA and RD_ADDR. It clears on each accepted byte and on every state entry.
  - Reaching TIMEOUT_CYCLES-1 without an rx_valid forces IDLE and pulses cmd_err in the next cycle.
  - The counter width is clog2(TIMEOUT_CYCLES).
- CMD_TIMEOUT_EN undefined: no counter is present; the byte-wait states wait indefinitely.

## Structure
- Package uart_ctrl_pkg holds:
  - the state enum;
  - opcode constants CMD_WR=8'hAA and CMD_RD=8'hBB.
- Sub-module cmd_timer holds the timeout counter; it is instantiated only under CMD_TIMEOUT_EN.
  - Inputs: clk, rst, clr, run.
  - Output: expired.

## Test plan
- Write: send 0xAA, 0x03, 0x5C. Expect one reg_wr_en, 2 cycles after the last rx_valid, with reg_addr=3 and reg_wr_data=0x5C. cmd_err stays 0.
- Read with tx_busy held high for 10 cycles after reg_rd_valid: send 0xBB, 0x07. Expect reg_rd_en, then return reg_rd_data=0xA5. Expect no tx_valid while busy, then exactly one tx_valid with tx_data=0xA5 one cycle after tx_busy is sampled 0.
- Bad input: send opcode 0x12 and expect a cmd_err pulse with the state remaining IDLE. Send 0xAA then 0x13 (ADDR_W=4) and expect cmd_err, return to IDLE, and no reg_wr_en.
- rx_err on the data byte of a write: expect cmd_err, no reg_wr_en, and return to IDLE. A following valid command then executes normally.
- With CMD_TIMEOUT_EN and TIMEOUT_CYCLES=16: send 0xBB then nothing. Expect cmd_err and busy=0 after 16 cycles. Without the macro, busy stays 1.
- Assert rst during RD_WAIT: expect all outputs to go to 0 immediately, and no tx_valid after release even if reg_rd_valid arrives.
